fir_mac_sequencer: RTL and testbench

FIR_MAC_SEQUENCER -- requirements
Module: fir_mac_sequencer

---
 rtl/fir_mac_sequencer.sv | 141 ++++++++++++++
 tb/tb_fir_mac_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_sequencer.sv
// Sequential FIR filter: one signed multiplier and one wide accumulator are
// time-shared across all taps, with a circular sample buffer and a coefficient table.
module fir_mac_sequencer #(
    parameter int NTAPS = 175,
    parameter int DW    = 16,
    parameter int ACCW  = 40
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic signed [DW-1:0] x,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic signed [DW-1:0] y,
    output logic                 out_valid,
    input  logic                 out_ready,
    input  logic                 coef_we,
    input  logic [7:0]           coef_addr,
    input  logic signed [DW-1:0] coef_data,
    output logic                 busy
);

    localparam int IW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
    localparam logic [IW-1:0] LAST = IW'(NTAPS - 1);

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                 state_q;
    logic [IW-1:0]          wptr_q, k_q, idx_d;
    logic signed [DW-1:0]   smp_q  [NTAPS];
    logic signed [DW-1:0]   coef_q [NTAPS];
    logic signed [2*DW-1:0] cx_d, sx_d, prod_d, prod_p1_q;
    logic                   last_p1_q;
    logic signed [ACCW-1:0] acc_q, acc_d;
    logic signed [DW-1:0]   y_q;
    logic                   in_ready_q, out_valid_q, busy_q;
    logic                   accept, coef_wr;

    // Q1.15 rescale of the accumulator with clamping to the output range.
    function automatic logic signed [DW-1:0] sat_q15(input logic signed [ACCW-1:0] a);
        logic signed [ACCW-1:0] s;
        s = a >>> (DW - 1);
        if ((&s[ACCW-1:DW-1]) || !(|s[ACCW-1:DW-1]))
            return s[DW-1:0];
        else if (s[ACCW-1])
            return {1'b1, {(DW-1){1'b0}}};
        else
            return {1'b0, {(DW-1){1'b1}}};
    endfunction

    assign accept  = in_valid && in_ready_q;
    assign coef_wr = coef_we && (state_q == IDLE) && (32'(coef_addr) < NTAPS);

    always_comb begin
        idx_d  = wptr_q - k_q + ((wptr_q < k_q) ? IW'(NTAPS) : '0);
        cx_d   = {{DW{coef_q[k_q][DW-1]}}, coef_q[k_q]};
        sx_d   = {{DW{smp_q[idx_d][DW-1]}}, smp_q[idx_d]};
        prod_d = cx_d * sx_d;
        acc_d  = acc_q + {{(ACCW-2*DW){prod_p1_q[2*DW-1]}}, prod_p1_q};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NTAPS; i++) begin
                smp_q[i]  <= '0;
                coef_q[i] <= '0;
            end
        end else begin
            if (accept)
                smp_q[wptr_q] <= x;
            if (coef_wr)
                coef_q[coef_addr[IW-1:0]] <= coef_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wptr_q      <= '0;
            k_q         <= '0;
            acc_q       <= '0;
            prod_p1_q   <= '0;
            last_p1_q   <= 1'b0;
            y_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q    <= MAC;
                        acc_q      <= '0;
                        prod_p1_q  <= '0;
                        last_p1_q  <= 1'b0;
                        k_q        <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                MAC: begin
                    acc_q <= acc_d;
                    // Product stage p1 feeds the accumulator one cycle later; the final
                    // cycle only drains it, so the result lands at edge NTAPS+1.
                    if (last_p1_q) begin
                        y_q         <= sat_q15(acc_d);
                        state_q     <= OUT;
                        out_valid_q <= 1'b1;
                        last_p1_q   <= 1'b0;
                        wptr_q      <= (wptr_q == LAST) ? '0 : wptr_q + 1'b1;
                    end else begin
                        prod_p1_q <= prod_d;
                        if (k_q == LAST)
                            last_p1_q <= 1'b1;
                        else
                            k_q <= k_q + 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign y         = y_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed and randomized bench for fir_mac_sequencer against a sum-of-products
// reference model over a circular sample history.
module tb_fir_mac_sequencer;

    localparam int NTAPS = 175;
    localparam int DW    = 16;
    localparam int ACCW  = 40;

    logic                 clk = 1'b0;
    logic                 reset;
    logic signed [DW-1:0] x;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] y;
    logic                 out_valid;
    logic                 out_ready;
    logic                 coef_we;
    logic [7:0]           coef_addr;
    logic signed [DW-1:0] coef_data;
    logic                 busy;

    fir_mac_sequencer #(.NTAPS(NTAPS), .DW(DW), .ACCW(ACCW)) dut (
        .clk       (clk),
        .reset     (reset),
        .x         (x),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic signed [15:0] ref_coef [NTAPS];
    logic signed [15:0] ref_smp  [NTAPS];
    int                 ref_wptr;
    int                 total;

    int                 bp_cycles = 0;
    int                 lock_at   = -1;
    logic               cw_en     = 1'b0;
    logic [7:0]         cw_addr   = 8'd0;
    logic signed [15:0] cw_data   = 16'sd0;

    task automatic chk1(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NTAPS; i++) begin
            ref_coef[i] = 16'sd0;
            ref_smp[i]  = 16'sd0;
        end
        ref_wptr = 0;
        total    = 0;
    endfunction

    // y = clamp((sum_k coef[k] * history[k]) >> 15), history[0] newest sample
    function automatic logic [15:0] model_y();
        longint acc = 0;
        for (int k = 0; k < NTAPS; k++)
            acc += longint'(ref_coef[k]) * longint'(ref_smp[(ref_wptr - k + NTAPS) % NTAPS]);
        acc = acc >>> 15;
        if (acc > 32767)  return 16'h7FFF;
        if (acc < -32768) return 16'h8000;
        return 16'(acc);
    endfunction

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        coef_we  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        model_reset();
    endtask

    task automatic write_coef(input int a, input logic signed [15:0] d);
        coef_we   = 1'b1;
        coef_addr = 8'(a);
        coef_data = d;
        @(negedge clk);
        coef_we = 1'b0;
        if (a < NTAPS) ref_coef[a] = d;
    endtask

    task automatic run_sample(input logic signed [15:0] xs, output logic [15:0] yv);
        logic [15:0] expv;
        int n;
        chk1("in_ready_idle", in_ready, 1'b1);
        out_ready = (bp_cycles == 0);
        x = xs;
        in_valid = 1'b1;
        if (cw_en) begin
            coef_we   = 1'b1;
            coef_addr = cw_addr;
            coef_data = cw_data;
            ref_coef[cw_addr] = cw_data;
        end
        ref_smp[ref_wptr] = xs;
        expv = model_y();
        ref_wptr = (ref_wptr + 1) % NTAPS;
        total++;
        @(negedge clk);
        in_valid = 1'b0;
        coef_we  = 1'b0;
        cw_en    = 1'b0;
        x = 16'($urandom);
        n = 0;
        while (!out_valid && n < NTAPS + 20) begin
            if (n == 1) begin
                chk1("busy_mac", busy, 1'b1);
                chk1("in_ready_mac", in_ready, 1'b0);
            end
            in_valid = (n == 2);
            if (n == lock_at) begin
                coef_we   = 1'b1;
                coef_addr = 8'd0;
                coef_data = 16'h7FFF;
            end else begin
                coef_we = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        coef_we  = 1'b0;
        chk16("latency", 16'(n), 16'(NTAPS + 1));
        chk16("y", y, expv);
        yv = y;
        for (int i = 0; i < bp_cycles; i++) begin
            in_valid = i[0];
            x = 16'($urandom);
            @(negedge clk);
            chk1("bp_out_valid", out_valid, 1'b1);
            chk1("bp_in_ready", in_ready, 1'b0);
            chk16("bp_y", y, expv);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk1("out_valid_drop", out_valid, 1'b0);
        chk1("in_ready_back", in_ready, 1'b1);
        chk1("busy_idle", busy, 1'b0);
        lock_at   = -1;
        bp_cycles = 0;
    endtask

    initial begin
        logic [15:0] yv;
        logic        saw_ov;
        int          v;

        reset = 1'b1;
        x = '0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        coef_we = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk1("rst_in_ready", in_ready, 1'b1);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk16("rst_y", y, 16'h0000);

        // impulse through an 8-tap ramp
        for (int k = 0; k < 8; k++) write_coef(k, 16'(16'h0100 * (k + 1)));
        for (int i = 0; i < 8; i++) begin
            run_sample((i == 0) ? 16'sh4000 : 16'sh0000, yv);
            chk16("impulse", yv, 16'(16'h0080 * (i + 1)));
        end

        // coefficient write during MAC must not land; out-of-range write ignored
        lock_at = 5;
        run_sample(16'sh2000, yv);
        write_coef(200, 16'sh7FFF);
        run_sample(16'sh1800, yv);

        // coefficient write in the acceptance cycle is used by that pass
        cw_en = 1'b1; cw_addr = 8'd0; cw_data = 16'sh0300;
        run_sample(16'sh1000, yv);

        // backpressure with dropped input pulses
        bp_cycles = 10;
        run_sample(-16'sh0C00, yv);

        // random coefficients, then random samples across the buffer wrap
        for (int k = 0; k < NTAPS; k++) begin
            v = int'($urandom_range(0, 8190)) - 4095;
            write_coef(k, 16'(v));
        end
        while (total < NTAPS + 3) begin
            if ((total % 8) == 0) v = int'($urandom_range(0, 65535)) - 32768;
            else                  v = int'($urandom_range(0, 8190)) - 4095;
            if ((total % 37) == 5) bp_cycles = int'($urandom_range(1, 4));
            run_sample(16'(v), yv);
        end

        // reset in the middle of a MAC pass
        x = 16'sh4000;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (50) @(negedge clk);
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        saw_ov = 1'b0;
        for (int i = 0; i < NTAPS + 5; i++) begin
            @(negedge clk);
            saw_ov = saw_ov | out_valid;
        end
        chk1("abort_no_out_valid", saw_ov, 1'b0);
        chk1("abort_in_ready", in_ready, 1'b1);
        chk1("abort_busy", busy, 1'b0);
        chk16("abort_y", y, 16'h0000);
        run_sample(16'sh4000, yv);
        chk16("abort_impulse", yv, 16'h0000);

        // positive saturation
        do_reset();
        for (int k = 0; k < NTAPS; k++) write_coef(k, 16'sh7FFF);
        for (int i = 0; i < 4; i++) run_sample(16'sh7FFF, yv);
        chk16("sat_pos", yv, 16'h7FFF);

        // negative saturation
        do_reset();
        for (int k = 0; k < NTAPS; k++) write_coef(k, 16'sh7FFF);
        for (int i = 0; i < 4; i++) run_sample(16'sh8000, yv);
        chk16("sat_neg", yv, 16'h8000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
